// File: rtl/seg_scan_driver_pkg.sv
// Shared constants, slot-state encoding and digit helpers for the 7-segment scan driver.
package seg_scan_driver_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam logic [7:0] SEG_CURSOR = 8'h08;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

  function automatic logic [7:0] digit_onehot(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  // {found, index} of the lowest-numbered empty digit in a frame
  function automatic logic [3:0] first_empty(input logic [63:0] frame);
    logic [3:0] res;
    res = 4'h0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (frame[8*i +: 8] == SEG_BLANK) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_scan_driver_prescaler.sv
// Parameterised mod-N counter with start (count 0), match (count MATCH) and wrap (count N-1) flags.
module seg_scan_driver_prescaler #(
  parameter int N     = 10,
  parameter int MATCH = 0,
  parameter int W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic clk,
  input  logic rst,
  output logic start,
  output logic match,
  output logic wrap
);

  localparam logic [W-1:0] LAST_V  = W'(N - 1);
  localparam logic [W-1:0] MATCH_V = W'(MATCH);

  logic [W-1:0] cnt_r;

  // Free-running count 0..N-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cnt_r <= {W{1'b0}};
    else if (cnt_r == LAST_V) cnt_r <= {W{1'b0}};
    else                      cnt_r <= cnt_r + W'(1'b1);
  end

  assign start = (cnt_r == {W{1'b0}});
  assign match = (cnt_r == MATCH_V);
  assign wrap  = (cnt_r == LAST_V);

endmodule

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed 7-segment driver with per-frame snapshot and dead-time blanking.
// Optional blinking underscore cursor on the lowest empty digit when SEG_BLINK_EN is defined.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 8_000,
  parameter int DEAD_CYC    = 16,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_HZ    = 2
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_in,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [2:0]  digit_idx,
  output logic        frame_strobe
);

  // DEAD_CYC must be at least 1 so the snapshot lands before the first DRIVE decision
  localparam int         SLOT_CYC = CLK_HZ / SCAN_HZ;
  localparam logic [7:0] AN_POL   = {8{AN_ACT_LOW}};
  localparam logic [7:0] SEG_POL  = {8{SEG_ACT_LOW}};

  logic        slot_start_s;
  logic        dead_end_s;
  logic        slot_wrap_s;
  logic        take_snap_s;
  logic [63:0] frame_s;
  logic [7:0]  byte_s;
  logic [7:0]  shown_s;

  slot_state_t state_r;
  logic [63:0] snap_r;
  logic [2:0]  digit_r;
  logic [7:0]  an_r;
  logic [7:0]  seg_r;
  logic        strobe_r;

  seg_scan_driver_prescaler #(
    .N     (SLOT_CYC),
    .MATCH (DEAD_CYC - 1)
  ) u_slot (
    .clk   (clk),
    .rst   (rst),
    .start (slot_start_s),
    .match (dead_end_s),
    .wrap  (slot_wrap_s)
  );

`ifdef SEG_BLINK_EN
  localparam int BLINK_CYC = CLK_HZ / (2 * BLINK_HZ);

  logic       blink_start_s;
  logic       blink_match_s;
  logic       blink_wrap_s;
  logic       phase_r;
  logic [3:0] cursor_s;

  seg_scan_driver_prescaler #(
    .N     (BLINK_CYC),
    .MATCH (0)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .start (blink_start_s),
    .match (blink_match_s),
    .wrap  (blink_wrap_s)
  );

  // Cursor phase: starts off, flips every half blink period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              phase_r <= 1'b0;
    else if (blink_wrap_s) phase_r <= ~phase_r;
    else                   phase_r <= phase_r;
  end
`endif

  // Byte for the current digit; the digit-0 slot sees the freshly captured frame
  always_comb begin
    take_snap_s = slot_start_s && (digit_r == 3'd0);
    if (take_snap_s) frame_s = seg_in;
    else             frame_s = snap_r;
    byte_s = frame_s[{digit_r, 3'b000} +: 8];
`ifdef SEG_BLINK_EN
    cursor_s = first_empty(frame_s);
    if (cursor_s[3] && (cursor_s[2:0] == digit_r) && phase_r) shown_s = SEG_CURSOR;
    else                                                       shown_s = byte_s;
`else
    shown_s = byte_s;
`endif
  end

  // Slot FSM, snapshot capture and registered pin drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= SLOT_BLANK;
      snap_r   <= 64'h0;
      digit_r  <= 3'd0;
      an_r     <= AN_POL;
      seg_r    <= SEG_POL;
      strobe_r <= 1'b0;
    end else begin
      strobe_r <= take_snap_s;
      if (take_snap_s) snap_r <= seg_in;
      else             snap_r <= snap_r;
      case (state_r)
        SLOT_BLANK: begin
          if (dead_end_s) begin
            state_r <= SLOT_DRIVE;
            seg_r   <= shown_s ^ SEG_POL;
            if (shown_s != SEG_BLANK) an_r <= digit_onehot(digit_r) ^ AN_POL;
            else                      an_r <= AN_POL;
          end else begin
            state_r <= SLOT_BLANK;
          end
        end
        SLOT_DRIVE: begin
          if (slot_wrap_s) begin
            state_r <= SLOT_BLANK;
            an_r    <= AN_POL;
            seg_r   <= SEG_POL;
            digit_r <= digit_r + 3'd1;
          end else begin
            state_r <= SLOT_DRIVE;
          end
        end
        default: begin
          state_r <= SLOT_BLANK;
          an_r    <= AN_POL;
          seg_r   <= SEG_POL;
        end
      endcase
    end
  end

  assign an           = an_r;
  assign seg          = seg_r;
  assign digit_idx    = digit_r;
  assign frame_strobe = strobe_r;

endmodule
